// File: rtl/mux_pkg.sv
// Shared types and default sizes for the operand selector family.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mux_state_e;

  localparam int MUX_WIDTH_DEF = 16;
  localparam int MUX_N_IN_DEF  = 3;

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N-input, WIDTH-bit binary-select multiplexer.
// Selects outside 0..N_IN-1 yield an all-zero word.
module mux_n_comb #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 3,
  parameter int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data
);

  logic [WIDTH-1:0] slot [N_IN];

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_slot
      assign slot[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) out_data = slot[k];
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-input operand selector with a 2-entry skid buffer behind valid/ready.
// Optional MUX_SEL_ERR_EN adds a sticky sel_err output for out-of-range selects.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int N_IN  = MUX_N_IN_DEF,
  localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
`ifdef MUX_SEL_ERR_EN
  output logic                  sel_err,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  mux_state_e       state_reg, state_next;
  logic [WIDTH-1:0] main_data_reg, skid_data_reg, cap_data;
  logic [SEL_W-1:0] main_sel_reg, skid_sel_reg;
  logic             accept, consume;
  logic             load_main_new, load_main_skid, load_skid;

  // Handshake outputs decode registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  assign out_data  = main_data_reg;
  assign out_sel   = main_sel_reg;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (cap_data)
  );

  always_comb begin
    state_next     = state_reg;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next    = ONE;
            load_main_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_sel_reg  <= '0;
      skid_data_reg <= '0;
      skid_sel_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main_new) begin
        main_data_reg <= cap_data;
        main_sel_reg  <= in_sel;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_sel_reg  <= skid_sel_reg;
      end
      if (load_skid) begin
        skid_data_reg <= cap_data;
        skid_sel_reg  <= in_sel;
      end else if (load_main_skid) begin
        skid_data_reg <= '0;
        skid_sel_reg  <= '0;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_oor;
  logic sel_err_reg;

  assign sel_oor = ({1'b0, in_sel} >= (SEL_W+1)'(N_IN));
  assign sel_err = sel_err_reg;

  // Sticky until reset; a flush deliberately leaves it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_reg <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_reg <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(accept && sel_oor))
        else $error("mux_sel_pipe: out-of-range select %0d accepted", in_sel);
    end
  end
`endif

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N-input operand selector for the CPU datapath; the next generation of the fixed 16-bit, 3-input selector. It picks one of `N_IN` words of `WIDTH` bits by a binary select. It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a stalled downstream stage never drops an operand and `out_ready` never combinationally reaches `in_ready`. It sits between the forwarding/register-read logic and the execute stage.

## Interface
- `WIDTH`, 16, data word width in bits (>= 1)
- `N_IN`, 3, number of selectable inputs (>= 2)
- `SEL_W`, derived localparam = max(1, $clog2(N_IN)), select width; not overridable

- `clk`  in  1  rising-edge clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- `in_sel`  in  SEL_W  binary select, sampled with `in_data`
- `in_valid`  in  1  upstream offers a select/data pair
- `in_ready`  out  1  block can accept this cycle
- `flush`  in  1  discard all held entries (pipeline flush)
- `out_data`  out  WIDTH  selected word, registered
- `out_sel`  out  SEL_W  select value that produced `out_data`
- `out_valid`  out  1  `out_data`/`out_sel` valid
- `out_ready`  in  1  downstream accepts this cycle

## Operation
- Accept = `in_valid && in_ready`; consume = `out_valid && out_ready`.
- Captured word = slice `in_sel` of `in_data`.
  - If `in_sel >= N_IN`, the captured word is all zeros (legacy default); `out_sel` still echoes the raw select.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: nothing held; `in_ready`=1, `out_valid`=0.
  - ONE: main valid; `in_ready`=1.
  - FULL: main and skid valid; `in_ready`=0.
- Transitions (no flush):
  - EMPTY + accept -> ONE.
  - ONE + accept, no consume -> FULL; the new entry goes to skid.
  - ONE + accept + consume -> ONE; main reloads with the new entry.
  - ONE + consume only -> EMPTY.
  - FULL + consume -> ONE; skid moves to main, skid clears.
  - All other combinations hold state.
- Order is strictly FIFO; entries are never reordered or duplicated.
- `flush`=1: next state EMPTY, whatever the current state. An accept in the same cycle is discarded. Flush beats accept and consume.
- Data registers update only on capture; they are don't-care while their valid is 0, except after reset.

## Timing
- Reset (async assert, sync release): state EMPTY, `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=1, skid cleared.
- Latency: accept at edge n -> `out_valid`=1 with that word after edge n (visible in cycle n+1). Minimum latency is 1 cycle.
- Throughput: 1 word/cycle while `out_ready`=1.
- `in_ready` is a pure function of registered state; there is no combinational path from `out_ready` or `in_*` to any output.
- Reset asserted mid-transfer: all held entries are lost and outputs return to reset values immediately.
- `in_data`/`in_sel` are sampled only on accept; changes while `in_ready`=0 are ignored.

## Configuration
- `MUX_SEL_ERR_EN` defined: adds output port `sel_err` (1 bit, reset 0).
  - `sel_err` is sticky; it sets one cycle after an accept with `in_sel >= N_IN`.
  - It clears only on `rst`; `flush` does not clear it.
  - With it defined, a simulation-only assertion also fires on that event.
- `MUX_SEL_ERR_EN` undefined: no `sel_err` port and no assertion. An out-of-range select silently yields zero.

## Structure
- Shared package `mux_pkg`:
  - state enum `mux_state_e` {EMPTY, ONE, FULL};
  - default constants `MUX_WIDTH_DEF`=16 and `MUX_N_IN_DEF`=3.
- Sub-module `mux_n_comb`: the purely combinational N-input, WIDTH-bit select with zero default. It is instantiated once to form the captured word and is reusable elsewhere in the core.
- The top level holds the state register, main/skid registers and the handshake logic.

## Test plan
- Reset: assert `rst` mid-stream -> `out_valid`=0, `out_data`=0, `in_ready`=1 the same cycle.
- Streaming, N_IN=3, WIDTH=16, inputs {0x1111, 0x2222, 0x3333}, sel sequence 0,1,2, `out_ready`=1 -> outputs 0x1111, 0x2222, 0x3333 on consecutive cycles, 1-cycle latency.
- Backpressure: `out_ready`=0, send sel=1 then sel=2 -> second accept enters FULL, `in_ready`=0. Raise `out_ready` -> 0x2222 then 0x3333 in order, nothing lost.
- Out of range: sel=3 with N_IN=3 -> `out_data`=0x0000, `out_sel`=3. With `MUX_SEL_ERR_EN`, `sel_err`=1 next cycle and it stays 1 after `flush`.
- Flush in FULL with simultaneous `in_valid`=1 -> next cycle EMPTY, `out_valid`=0, `in_ready`=1, and the offered word never appears.
- Parameter sweep N_IN=5, WIDTH=32, sel=4, data 0xDEADBEEF on slot 4 -> `out_data`=0xDEADBEEF.
